// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, WIDTH-bit operands.
// Define MULDIV_EARLY_OUT_EN to retire zero-operand and overflow cases directly from PREP.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               spec_q, spec_d;
  logic [WIDTH-1:0]   spec_res_q, spec_res_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_div, a_signed, b_signed, sign_a, sign_b;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   mag_a, mag_b, spec_res, fix_res, quo, rem;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;

  // Operand decode works on the latched request so PREP is independent of the live inputs.
  always_comb begin
    is_div   = op_q[2];
    a_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    b_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    sign_a   = a_signed & a_q[WIDTH-1];
    sign_b   = b_signed & b_q[WIDTH-1];
    mag_a    = sign_a ? -a_q : a_q;
    mag_b    = sign_b ? -b_q : b_q;
    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && !op_q[0] && (a_q == MinVal) && (b_q == '1);
    spec_res = '0;
    if (div_zero) begin
      spec_res = op_q[1] ? a_q : '1;
    end else if (div_ovf) begin
      spec_res = op_q[1] ? '0 : a_q;
    end
`ifdef MULDIV_EARLY_OUT_EN
    special = div_zero || div_ovf || (!is_div && ((a_q == '0) || (b_q == '0)));
`else
    special = div_zero || div_ovf;
`endif
  end

  // One iteration step; prod_q holds {acc, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_neg = neg_q ? -prod_q : prod_q;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'd0:          fix_res = prod_neg[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_neg[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:    fix_res = neg_q ? -quo : quo;
      default:       fix_res = neg_q ? -rem : rem;
    endcase
    if (spec_q) fix_res = spec_res_q;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
          state_d = StPrep;
        end
      end
      StPrep: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          neg_d      = (is_div && op_q[1]) ? sign_a : (sign_a ^ sign_b);
          prod_d     = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          opnd_d     = is_div ? mag_b : mag_a;
          cnt_d      = '0;
          spec_d     = special;
          spec_res_d = spec_res;
          state_d    = StIter;
`ifdef MULDIV_EARLY_OUT_EN
          if (special) begin
            result_d = spec_res;
            state_d  = StDone;
          end
`endif
        end
      end
      StIter: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          prod_d = is_div ? div_next : mul_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StFix;
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized ops against an
// arithmetic reference model; also covers flush, mid-operation reset and a WIDTH=8 instance.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        Clk, Reset;
  logic        start, flush, ready, done;
  logic [2:0]  op;
  logic [31:0] opA, opB, result;
  logic        start8, flush8, ready8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .ready(ready), .done(done), .result(result)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .start(start8), .op(op8), .opA(a8), .opB(b8),
    .flush(flush8), .ready(ready8), .done(done8), .result(result8)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: RV32M semantics from plain wide arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] xa, xb, p;
    longint      sa, sb;
    if (!o[2]) begin
      xa = (o == 3'd1 || o == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (o == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      return (o == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = o[1] ? 64'(sa % sb) : 64'(sa / sb);
      return p[31:0];
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit spec;
    spec = (o[2] && b == 32'd0) ||
           ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
           (!o[2] && (a == 32'd0 || b == 32'd0));
    return (Early && spec) ? 1 : 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge Clk);
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0; opA = $urandom; opB = $urandom; op = 3'($urandom);
  endtask

  // lat = rising edges after the accept edge before done is seen.
  task automatic wait_done(output logic [31:0] res, output int lat);
    lat = 0;
    @(negedge Clk);
    while (done !== 1'b1 && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    res = result;
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want, input int want_lat);
    logic [31:0] res;
    int          lat;
    issue(o, a, b);
    wait_done(res, lat);
    total++;
    if (res !== want) begin
      bad++;
      $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h", name, o, a, b, res, want);
    end
    total++;
    if (lat !== want_lat) begin
      bad++;
      $display("FAIL %s latency op=%0d: got %0d want %0d", name, o, lat, want_lat);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset result: got %h want 0", result); end
    total++; if (ready8 !== 1'b1) begin bad++; $display("FAIL reset ready8: got %b want 1", ready8); end
    Reset = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
  } vec_t;

  vec_t vecs[7] = '{
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF},
    '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD}
  };

  task automatic test_vectors();
    for (int i = 0; i < 7; i++) begin
      check_op("vector", vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].want,
               exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      check_op("random", o, a, b, ref_model(o, a, b), exp_lat(o, a, b));
    end
  endtask

  task automatic test_done_pulse();
    check_op("pulse_op", 3'd0, 32'd3, 32'd5, 32'd15, 34);
    @(negedge Clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL pulse done: got %b want 0", done); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL pulse ready: got %b want 1", ready); end
    total++; if (result !== 32'd15) begin bad++; $display("FAIL pulse hold: got %h want %h", result, 32'd15); end
  endtask

  task automatic test_flush();
    int dones = 0;
    issue(3'd0, 32'd7, 32'd6);
    repeat (10) @(negedge Clk);
    flush = 1'b1;
    @(posedge Clk);
    #1 flush = 1'b0;
    @(negedge Clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush ready: got %b want 1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush done: got %b want 0", done); end
    total++; if (result !== 32'd15) begin bad++; $display("FAIL flush result: got %h want %h", result, 32'd15); end
    repeat (40) begin
      @(negedge Clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL flush no_done: got %0d want 0", dones); end
    check_op("reissue", 3'd0, 32'd7, 32'd6, 32'd42, 34);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = $urandom | 32'h1;
    b = ($urandom & 32'hFF) | 32'h3;
    issue(3'd5, a, b);
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset ready: got %b want 1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset done: got %b want 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL midreset result: got %h want 0", result); end
    check_op("after_reset", 3'd5, a, b, a / b, 34);
  endtask

  task automatic test_width8();
    logic [2:0] ops[3]   = '{3'd3, 3'd0, 3'd4};
    logic [7:0] as[3]    = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0] bs[3]    = '{8'hFF, 8'hFF, 8'hFF};
    logic [7:0] wants[3] = '{8'hFE, 8'h01, 8'h80};
    int         lats[3];
    int         lat, guard;
    lats[0] = 10; lats[1] = 10; lats[2] = Early ? 1 : 10;
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      @(negedge Clk);
      while (ready8 !== 1'b1 && guard < 200) begin @(negedge Clk); guard++; end
      op8 = ops[i]; a8 = as[i]; b8 = bs[i]; start8 = 1'b1;
      @(posedge Clk);
      #1 start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      @(negedge Clk);
      while (done8 !== 1'b1 && lat < 100) begin @(negedge Clk); lat++; end
      total++;
      if (result8 !== wants[i]) begin
        bad++;
        $display("FAIL w8 result op=%0d: got %h want %h", ops[i], result8, wants[i]);
      end
      total++;
      if (lat !== lats[i]) begin
        bad++;
        $display("FAIL w8 latency op=%0d: got %0d want %0d", ops[i], lat, lats[i]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; opA = '0; opB = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_vectors();
    test_random();
    test_done_pulse();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
